// File: rtl/striping_pkg.sv
// Shared constants and types for the byte striper and its lane registers.
package striping_pkg;

    localparam int LANES        = 2;
    localparam int WORD_W       = 32;
    localparam int CNT_W_DEF    = 16;
    localparam int IDLE_GAP_DEF = 2;
    localparam int GAP_W        = 4;

    typedef logic lane_idx_t;

    localparam lane_idx_t LANE_0 = 1'b0;
    localparam lane_idx_t LANE_1 = 1'b1;

    // Saturating increment of the idle counter.
    function automatic logic [GAP_W-1:0] gap_next(input logic [GAP_W-1:0] gap,
                                                  input logic [GAP_W-1:0] gap_max);
        logic [GAP_W-1:0] res;
        if (gap < gap_max) begin
            res = gap + 4'd1;
        end else begin
            res = gap_max;
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_striping_if.sv
// Word input and two-lane output bundle of the byte striper.
interface byte_striping_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             valid_0;
    logic [WIDTH-1:0] lane_0;
    logic             valid_1;
    logic [WIDTH-1:0] lane_1;
    logic [CNT_W-1:0] cnt_0;
    logic [CNT_W-1:0] cnt_1;
    logic             odd_burst;

    modport master (
        output valid_in, data_in,
        input  valid_0, lane_0, valid_1, lane_1, cnt_0, cnt_1, odd_burst
    );

    modport slave (
        input  valid_in, data_in,
        output valid_0, lane_0, valid_1, lane_1, cnt_0, cnt_1, odd_burst
    );
endinterface

// File: rtl/byte_striping_lane.sv
// One output lane: data/valid registers plus a wrapping count of words sent.
module byte_striping_lane #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: capture on write, otherwise hold data and drop valid.
    always_comb begin
        valid_d = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            valid_d = 1'b0;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/byte_striping.sv
// Alternates input words onto two lanes, realigning to lane 0 after an idle gap
// and flagging bursts that ended on an unpaired lane-0 word.
module byte_striping
    import striping_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int IDLE_GAP = IDLE_GAP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    byte_striping_if.slave bus
);

    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_GAP);

    lane_idx_t        sel_q, sel_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             odd_q, odd_d;
    logic             wr_0_s, wr_1_s;

    // Lane steering, idle counting and realignment decision.
    always_comb begin
        sel_d  = sel_q;
        gap_d  = gap_q;
        odd_d  = 1'b0;
        wr_0_s = 1'b0;
        wr_1_s = 1'b0;
        if (bus.valid_in) begin
            wr_0_s = (sel_q == LANE_0);
            wr_1_s = (sel_q == LANE_1);
            sel_d  = ~sel_q;
            gap_d  = '0;
        end else begin
            gap_d = gap_next(gap_q, GAP_MAX);
            // Realign only on the transition into the saturated state.
            if ((gap_q != GAP_MAX) && (gap_d == GAP_MAX)) begin
                sel_d = LANE_0;
                odd_d = (sel_q == LANE_1);
            end else begin
                sel_d = sel_q;
                odd_d = 1'b0;
            end
        end
    end

    // Steering state and registered odd-burst pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= LANE_0;
            gap_q <= '0;
            odd_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            gap_q <= gap_d;
            odd_q <= odd_d;
        end
    end

    byte_striping_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (wr_0_s),
        .data_i  (bus.data_in),
        .valid_o (bus.valid_0),
        .data_o  (bus.lane_0),
        .cnt_o   (bus.cnt_0)
    );

    byte_striping_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane_1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (wr_1_s),
        .data_i  (bus.data_in),
        .valid_o (bus.valid_1),
        .data_o  (bus.lane_1),
        .cnt_o   (bus.cnt_1)
    );

    assign bus.odd_burst = odd_q;

endmodule
